// File: rtl/strobe_period_monitor.sv
// Measures the interval between single-cycle strobes, locks once enough consecutive
// intervals fall inside EXPECTED +/- TOLERANCE, and flags loss of lock or a missing strobe.
module strobe_period_monitor #(
    parameter logic [19:0] EXPECTED   = 20'd16,
    parameter logic [19:0] TOLERANCE  = 20'd0,
    parameter logic [7:0]  LOCK_COUNT = 8'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        strobe_in,
    output logic [19:0] period_out,
    output logic        period_valid,
    output logic        locked,
    output logic        error,
    output logic [7:0]  err_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        LOCK    = 2'd2
    } state_t;

    // Window bounds are 21 bits so EXPECTED+TOLERANCE never overflows the compare.
    localparam logic [20:0] WIN_LO  = {1'b0, EXPECTED} - {1'b0, TOLERANCE};
    localparam logic [20:0] WIN_HI  = {1'b0, EXPECTED} + {1'b0, TOLERANCE};
    localparam logic [19:0] TMO_CNT = WIN_HI[19:0];
    localparam logic [19:0] CNT_MAX = 20'hFFFFF;

    state_t      state;
    logic [19:0] cnt;
    logic [7:0]  match_cnt;

    logic        in_tol;
    logic        timeout;
    logic        lock_hit;
    logic [7:0]  err_count_inc;

    always_comb begin
        in_tol        = ({1'b0, cnt} >= WIN_LO) && ({1'b0, cnt} <= WIN_HI);
        timeout       = !strobe_in && (cnt == TMO_CNT);
        lock_hit      = ({1'b0, match_cnt} + 9'd1) == {1'b0, LOCK_COUNT};
        err_count_inc = (err_count != 8'hFF) ? err_count + 8'd1 : err_count;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            match_cnt    <= '0;
            period_out   <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            error        <= 1'b0;
            err_count    <= '0;
        end else begin
            period_valid <= 1'b0;
            error        <= 1'b0;

            if (strobe_in)
                cnt <= 20'd1;
            else if (cnt != CNT_MAX)
                cnt <= cnt + 20'd1;

            case (state)
                IDLE: begin
                    // First strobe only establishes the reference edge.
                    if (strobe_in) begin
                        state     <= MEASURE;
                        match_cnt <= '0;
                    end
                end

                MEASURE: begin
                    if (strobe_in) begin
                        period_out   <= cnt;
                        period_valid <= 1'b1;
                        if (in_tol) begin
                            match_cnt <= match_cnt + 8'd1;
                            if (lock_hit) begin
                                state  <= LOCK;
                                locked <= 1'b1;
                            end
                        end else begin
                            match_cnt <= '0;
                        end
                    end else if (timeout) begin
                        state     <= IDLE;
                        match_cnt <= '0;
                    end
                end

                LOCK: begin
                    if (strobe_in) begin
                        period_out   <= cnt;
                        period_valid <= 1'b1;
                        if (!in_tol) begin
                            state     <= MEASURE;
                            locked    <= 1'b0;
                            error     <= 1'b1;
                            err_count <= err_count_inc;
                            match_cnt <= '0;
                        end
                    end else if (timeout) begin
                        // Missing strobe while locked: drop back to waiting for a reference.
                        state     <= IDLE;
                        locked    <= 1'b0;
                        error     <= 1'b1;
                        err_count <= err_count_inc;
                        match_cnt <= '0;
                    end
                end

                default: begin
                    state     <= IDLE;
                    locked    <= 1'b0;
                    match_cnt <= '0;
                end
            endcase
        end
    end

endmodule
